// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM encoding for the UART transmit arbiter.
package uart_pkg;
    localparam int BYTE_W           = 8;
    localparam int ACK_TIMEOUT_DEF  = 16;
    localparam int LOCK_TIMEOUT_DEF = 4096;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_ptr with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);
    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        // Walk from the farthest offset back to the pointer so the nearest requester wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (i_req[j]) begin
                o_gnt = NUM_REQ'(1) << j;
                o_idx = IW'(j);
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one uart_tx between producers,
// with start/busy handshake sequencing and ACK/lock timeouts.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_tx_start,
    output logic [BYTE_W-1:0]         o_tx_data,
    input  logic                      i_tx_busy,
    output logic                      o_arb_busy,
    output logic                      o_err_timeout
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = $clog2(ACK_TIMEOUT);
    localparam int LW = $clog2(LOCK_TIMEOUT);

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant, r_req_ready;
    logic [IW-1:0]       r_owner, r_ptr;
    logic                r_lock, r_last, r_tx_start, r_err;
    logic [BYTE_W-1:0]   r_tx_data;
    logic [AW-1:0]       r_ack_cnt;
    logic [LW-1:0]       r_lock_cnt;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [IW-1:0]       w_idx, w_owner_next;
    logic                w_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req(i_req_valid),
        .i_ptr(r_ptr),
        .o_gnt(w_gnt),
        .o_idx(w_idx),
        .o_any(w_any)
    );

    assign w_owner_next = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_req_ready <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_lock      <= 1'b0;
            r_last      <= 1'b0;
            r_tx_start  <= 1'b0;
            r_err       <= 1'b0;
            r_tx_data   <= '0;
            r_ack_cnt   <= '0;
            r_lock_cnt  <= '0;
        end else begin
            r_req_ready <= '0;
            r_tx_start  <= 1'b0;
            case (r_state)
                // A foreign driver holding tx_busy keeps the arbiter parked here.
                IDLE: if (!i_tx_busy) begin
                    if (r_lock) begin
                        if (i_req_valid[r_owner]) begin
                            r_req_ready <= r_grant;
                            r_state     <= LOAD;
                        end else if (r_lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
                            r_err   <= 1'b1;
                            r_lock  <= 1'b0;
                            r_grant <= '0;
                            r_ptr   <= w_owner_next;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end else if (w_any) begin
                        r_grant     <= w_gnt;
                        r_owner     <= w_idx;
                        r_req_ready <= w_gnt;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_data  <= i_req_data[BYTE_W*r_owner +: BYTE_W];
                    r_last     <= i_req_last[r_owner];
                    r_tx_start <= 1'b1;
                    r_ack_cnt  <= '0;
                    r_lock_cnt <= '0;
                    r_state    <= START;
                end
                // The start-pulse cycle already counts toward the ACK window.
                START: begin
                    r_ack_cnt <= r_ack_cnt + 1'b1;
                    r_state   <= WAIT_ACK;
                end
                WAIT_ACK: if (i_tx_busy) begin
                    r_state <= WAIT_DONE;
                end else if (r_ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    r_err   <= 1'b1;
                    r_lock  <= 1'b0;
                    r_grant <= '0;
                    r_state <= IDLE;
                end else begin
                    r_ack_cnt <= r_ack_cnt + 1'b1;
                end
                WAIT_DONE: if (!i_tx_busy) begin
                    r_state <= IDLE;
                    r_lock  <= !r_last;
                    if (r_last) begin
                        r_grant <= '0;
                        r_ptr   <= w_owner_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_grant       = r_grant;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;
    assign o_arb_busy    = r_state != IDLE;
    assign o_err_timeout = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench; requesters and a behavioural uart_tx drive the arbiter,
// a monitor pops expected (owner, byte) pairs on every tx_start.
module tb_uart_tx_arbiter;
    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     i_req_valid, i_req_last;
    logic [8*N-1:0]   i_req_data;
    logic [N-1:0]     o_req_ready, o_grant;
    logic             o_tx_start, o_arb_busy, o_err_timeout;
    logic [7:0]       o_tx_data;
    logic             tx_busy;

    int n_cmp = 0, n_err = 0;
    int scnt = 0;
    int rcnt [N];
    int busy_len = 20;
    int bcnt;
    logic model_en = 1'b1;
    logic prev_start = 1'b0;
    logic [N-1:0] rdy_s;
    logic [9:0] exp_q [$];
    logic [8:0] q0 [$], q1 [$], q2 [$];

    uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(16), .LOCK_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
        .o_req_ready(o_req_ready), .o_grant(o_grant),
        .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_busy(tx_busy),
        .o_arb_busy(o_arb_busy), .o_err_timeout(o_err_timeout)
    );

    always #5 clk = ~clk;

    // Behavioural uart_tx: busy rises the cycle after an accepted start, lasts busy_len cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_busy <= 1'b0;
            bcnt    <= 0;
        end else if (tx_busy) begin
            if (bcnt <= 1) tx_busy <= 1'b0;
            bcnt <= bcnt - 1;
        end else if (model_en && o_tx_start) begin
            tx_busy <= 1'b1;
            bcnt    <= busy_len;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_req(input int i, input logic [7:0] d, input logic l);
        case (i)
            0: q0.push_back({l, d});
            1: q1.push_back({l, d});
            default: q2.push_back({l, d});
        endcase
    endtask

    task automatic push_exp(input int i, input logic [7:0] d);
        exp_q.push_back({2'(i), d});
    endtask

    // Requesters: present the queue head, advance the cycle after their ready pulse.
    initial begin
        i_req_valid = '0;
        i_req_last  = '0;
        i_req_data  = '0;
        forever begin
            @(negedge clk);
            rdy_s = o_req_ready;
            @(posedge clk);
            #1;
            if (rdy_s[0] && q0.size() > 0) void'(q0.pop_front());
            if (rdy_s[1] && q1.size() > 0) void'(q1.pop_front());
            if (rdy_s[2] && q2.size() > 0) void'(q2.pop_front());
            i_req_valid = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
            i_req_last  = {q2.size() != 0 ? q2[0][8] : 1'b0,
                           q1.size() != 0 ? q1[0][8] : 1'b0,
                           q0.size() != 0 ? q0[0][8] : 1'b0};
            i_req_data  = {q2.size() != 0 ? q2[0][7:0] : 8'h00,
                           q1.size() != 0 ? q1[0][7:0] : 8'h00,
                           q0.size() != 0 ? q0[0][7:0] : 8'h00};
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (o_req_ready != '0) begin
                    chk("ready_onehot", 32'($onehot(o_req_ready)), 1);
                    chk("ready_vs_grant", 32'(o_req_ready), 32'(o_grant));
                    for (int i = 0; i < N; i++) rcnt[i] += int'(o_req_ready[i]);
                end
                if (o_tx_start) begin
                    chk("no_back_to_back_start", 32'(prev_start), 0);
                    scnt++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_start: tx_data 0x%0h, no byte expected at %0t", o_tx_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", 32'(o_tx_data), 32'(e[7:0]));
                        chk("tx_grant", 32'(o_grant), 32'(3'b001 << e[9:8]));
                    end
                end
                prev_start = o_tx_start;
            end else begin
                prev_start = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        exp_q.delete();
        @(negedge clk);
        scnt     = 0;
        rcnt     = '{0, 0, 0};
        model_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_start(input string nm, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_tx_start && n < lim);
        chk(nm, 32'(o_tx_start), 1);
    endtask

    task automatic wait_drain(input string nm, input int lim);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !o_arb_busy && !tx_busy &&
                     q0.size() == 0 && q1.size() == 0 && q2.size() == 0) && n < lim);
        chk(nm, {29'd0, exp_q.size() == 0, o_arb_busy, tx_busy}, 32'b100);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        rcnt = '{0, 0, 0};
        @(negedge clk);
        chk("reset_outputs", {o_grant, o_req_ready, o_tx_start, o_tx_data, o_arb_busy, o_err_timeout}, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single byte with a realistic 2610-cycle transmitter.
        busy_len = 2610;
        push_req(0, 8'h41, 1'b1);
        push_exp(0, 8'h41);
        wait_drain("t1_drain", 3000);
        chk("t1_ready_cnt", rcnt[0], 1);
        chk("t1_start_cnt", scnt, 1);
        chk("t1_grant_idle", 32'(o_grant), 0);
        chk("t1_no_err", 32'(o_err_timeout), 0);

        // Two contenders, pointer at 0: alternation 0,2,0,2.
        do_reset();
        busy_len = 20;
        push_req(0, 8'hA0, 1'b1);
        push_req(0, 8'hA1, 1'b1);
        push_req(2, 8'hC0, 1'b1);
        push_req(2, 8'hC1, 1'b1);
        push_exp(0, 8'hA0);
        push_exp(2, 8'hC0);
        push_exp(0, 8'hA1);
        push_exp(2, 8'hC1);
        wait_drain("t2_drain", 400);
        chk("t2_ready0", rcnt[0], 2);
        chk("t2_ready2", rcnt[2], 2);

        // Locked packet from req1 holds off req0.
        do_reset();
        push_req(1, 8'h10, 1'b0);
        push_req(1, 8'h11, 1'b0);
        push_req(1, 8'h12, 1'b1);
        push_exp(1, 8'h10);
        push_exp(1, 8'h11);
        push_exp(1, 8'h12);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_grant != 3'b010 && n < 20);
        chk("t3_grant_req1", 32'(o_grant), 32'b010);
        push_req(0, 8'h05, 1'b1);
        push_exp(0, 8'h05);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(scnt >= 1 && !o_arb_busy) && n < 100);
        chk("t3_lock_hold_grant", 32'(o_grant), 32'b010);
        wait_drain("t3_drain", 400);
        chk("t3_ready1", rcnt[1], 3);

        // Transmitter never answers: ACK timeout, then service resumes.
        do_reset();
        model_en = 1'b0;
        push_req(0, 8'h55, 1'b1);
        push_exp(0, 8'h55);
        wait_start("t4_start", 20);
        n = 0;
        while (!o_err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ack_latency", n, 16);
        chk("t4_grant_cleared", 32'(o_grant), 0);
        chk("t4_fsm_idle", 32'(o_arb_busy), 0);
        model_en = 1'b1;
        push_req(1, 8'h66, 1'b1);
        push_exp(1, 8'h66);
        wait_drain("t4_drain", 200);
        chk("t4_ready1", rcnt[1], 1);

        // Owner abandons its packet: LOCK timeout, then req0 served.
        do_reset();
        push_req(2, 8'h22, 1'b0);
        push_exp(2, 8'h22);
        wait_start("t5_start", 20);
        push_req(0, 8'h01, 1'b1);
        push_exp(0, 8'h01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!o_arb_busy && !tx_busy) && n < 100);
        n = 0;
        while (!o_err_timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_lock_latency", n, 64);
        chk("t5_req0_held_off", scnt, 1);
        wait_drain("t5_drain", 200);
        chk("t5_err_sticky", 32'(o_err_timeout), 1);
        chk("t5_ready0", rcnt[0], 1);

        // Reset asserted in the middle of WAIT_DONE.
        do_reset();
        busy_len = 200;
        push_req(0, 8'hA5, 1'b1);
        push_exp(0, 8'hA5);
        wait_start("t6_start", 20);
        repeat (5) @(negedge clk);
        chk("t6_in_wait_done", {30'd0, o_arb_busy, tx_busy}, 32'b11);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_reset_outs", {o_grant, o_req_ready, o_tx_start, o_tx_data, o_arb_busy, o_err_timeout}, 0);
        q0.delete();
        exp_q.delete();
        scnt = 0;
        rcnt = '{0, 0, 0};
        @(negedge clk);
        rst = 1'b1;
        busy_len = 20;
        push_req(1, 8'h5A, 1'b1);
        push_exp(1, 8'h5A);
        wait_drain("t6_drain", 200);
        chk("t6_ready1", rcnt[1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1);
    end
endmodule
